// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared types and constants for the 16-way round-robin grant arbiter.
//   NUM_REQ     : number of requesters (fixed at 16)
//   ID_W        : width of the binary grant index
//   arb_state_t : two-state arbiter FSM encoding
//   req_id_t    : binary requester index
//   arb_dbg_t   : internal state exposed on the top-level debug port
package rr_encoder_arbiter_pkg;

  localparam int NUM_REQ = 16;
  localparam int ID_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    arb_state_t  state;
    req_id_t     ptr;
    logic [7:0]  hold_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Requester-bank / arbiter bus.
//   enable      : arbitration enable (driven by master)
//   req         : per-requester request levels (driven by master)
//   grant       : registered one-hot grant (driven by slave = arbiter)
//   grant_id    : binary index of grant, 0 when idle
//   grant_valid : high exactly while grant is non-zero
//   timeout     : one-cycle pulse when a grant was cut by the hold limit
// Handshake: req[i] is a level held by requester i for as long as it wants
// or uses the resource; grant[i] is valid while grant_valid is high and is
// withdrawn by the arbiter after req[i] drops, enable drops, or the hold
// limit expires. There is no separate ready: dropping req is the release.
interface rr_encoder_arbiter_if;
  import rr_encoder_arbiter_pkg::*;

  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_id;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output enable, req,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  enable, req,
    output grant, grant_id, grant_valid, timeout
  );

endinterface

// File: rtl/rr_encoder_arbiter_pick.sv
// Combinational round-robin pick: the first set req bit at or above ptr,
// wrapping from the top bit back to bit 0.
//   req   : request vector
//   ptr   : highest-priority index for this search
//   found : at least one request is set
//   pick  : index of the chosen request (0 when none)
module rr_priority_pick
  import rr_encoder_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic               found,
  output req_id_t            pick
);

  logic [NUM_REQ-1:0] rot;
  req_id_t            offset;

  always_comb begin
    // Rotate so that bit ptr lands at position 0; the doubled vector makes
    // the wrap-around a plain shift.
    rot    = NUM_REQ'({req, req} >> ptr);
    found  = |rot;
    offset = '0;
    // Walk downward so the lowest set bit wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = req_id_t'(i);
    end
    // Un-rotate; the sum wraps naturally in ID_W bits.
    pick = found ? req_id_t'(ptr + offset) : '0;
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters, with
// registered one-hot grant, binary grant index and bounded grant tenure.
//   clk      : clock, all state on rising edge
//   reset    : asynchronous, active-high
//   bus      : requester/arbiter bus (slave side)
//   dbg      : FSM state, round-robin pointer and hold counter
// MAX_HOLD : maximum consecutive grant cycles, legal range 1..255.
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_encoder_arbiter_if.slave  bus,
  output arb_dbg_t             dbg
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t          state;
  req_id_t             ptr;
  logic [7:0]          hold_cnt;
  logic [NUM_REQ-1:0]  grant_q;
  req_id_t             grant_id_q;
  logic                grant_valid_q;
  logic                timeout_q;

  logic                found;
  req_id_t             pick;
  logic                hold_hit;
  logic                req_live;
  logic                release_now;

  rr_priority_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .pick  (pick)
  );

  assign hold_hit    = (hold_cnt == HOLD_LAST);
  assign req_live    = bus.req[grant_id_q];
  assign release_now = ~bus.enable | ~req_live | hold_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.enable && found) begin
            grant_q       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            grant_id_q    <= pick;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt      <= '0;
            ptr           <= grant_id_q + req_id_t'(1);
            state         <= IDLE;
            // Only a pure hold-limit expiry is reported; a coincident req
            // drop or enable drop counts as an ordinary release.
            timeout_q     <= hold_hit & bus.enable & req_live;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  assign dbg = '{state: state, ptr: ptr, hold_cnt: hold_cnt};

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Bench for rr_encoder_arbiter: directed and random request patterns, a
// grant scoreboard (id, duration, timeout-at-release) and per-cycle
// output invariants.
module tb_rr_encoder_arbiter;
  import rr_encoder_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rr_encoder_arbiter_if bus_if ();
  arb_dbg_t             dbg;

  rr_encoder_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .dbg   (dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {timeout_at_release, duration[7:0], id[3:0]}
  logic [12:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int to_cnt       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input logic [3:0] id, input logic [7:0] dur, input logic to);
    return {to, dur, id};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic        in_grant = 1'b0;
  int          cnt      = 0;
  logic [12:0] cur      = '0;

  always @(negedge clk) begin
    if (reset) begin
      in_grant = 1'b0;
      cnt      = 0;
    end else begin
      check("valid_vs_grant", 32'(bus_if.grant_valid), 32'(|bus_if.grant));
      check("onehot", 32'($countones(bus_if.grant) <= 1), 32'd1);
      if (bus_if.timeout) to_cnt++;
      if (bus_if.grant_valid && !in_grant) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(bus_if.grant_id), 32'hFFFF_FFFF);
          cur = {1'b0, 8'd0, bus_if.grant_id};
        end else begin
          cur = exp_q.pop_front();
          check("grant_id", 32'(bus_if.grant_id), 32'(cur[3:0]));
        end
        check("grant_decode", 32'(bus_if.grant), 32'd1 << bus_if.grant_id);
        check("timeout_in_grant", 32'(bus_if.timeout), 32'd0);
        in_grant = 1'b1;
        cnt      = 1;
      end else if (bus_if.grant_valid && in_grant) begin
        check("grant_id_stable", 32'(bus_if.grant_id), 32'(cur[3:0]));
        check("timeout_in_grant", 32'(bus_if.timeout), 32'd0);
        cnt++;
      end else if (!bus_if.grant_valid && in_grant) begin
        check("grant_duration", 32'(cnt), 32'(cur[11:4]));
        check("timeout_at_release", 32'(bus_if.timeout), 32'(cur[12]));
        check("id_idle", 32'(bus_if.grant_id), 32'd0);
        in_grant = 1'b0;
      end else begin
        check("timeout_idle", 32'(bus_if.timeout), 32'd0);
        check("id_idle", 32'(bus_if.grant_id), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int to_base;
    int rid;
    int rh;

    bus_if.enable = 1'b0;
    bus_if.req    = '0;

    // Reset values
    tick(2);
    check("rst_grant",   32'(bus_if.grant), 32'd0);
    check("rst_id",      32'(bus_if.grant_id), 32'd0);
    check("rst_valid",   32'(bus_if.grant_valid), 32'd0);
    check("rst_timeout", 32'(bus_if.timeout), 32'd0);
    check("rst_state",   32'(dbg.state), 32'(IDLE));
    check("rst_ptr",     32'(dbg.ptr), 32'd0);
    reset = 1'b0;
    tick(1);

    // Single requester 4, held 3 edges then dropped
    bus_if.enable = 1'b1;
    bus_if.req    = 16'h0010;
    exp_q.push_back(mk(4'd4, 8'd3, 1'b0));
    tick(3);
    bus_if.req = '0;
    tick(3);
    check("t1_ptr", 32'(dbg.ptr), 32'd5);
    check("t1_timeouts", 32'(to_cnt), 32'd0);

    // ptr=5, req 0 and 4: wrap reaches 0 first, then 4 is served
    bus_if.req = 16'h0011;
    exp_q.push_back(mk(4'd0, 8'd3, 1'b0));
    exp_q.push_back(mk(4'd4, 8'd2, 1'b0));
    tick(3);
    bus_if.req = 16'h0010;
    tick(3);
    bus_if.req = '0;
    tick(3);
    check("t2_ptr", 32'(dbg.ptr), 32'd5);

    // All requesting from ptr=0: 0..15,0, each 8 cycles with timeout
    reset = 1'b1;
    tick(1);
    reset   = 1'b0;
    to_base = to_cnt;
    bus_if.req = 16'hFFFF;
    for (int k = 0; k < 17; k++) exp_q.push_back(mk(4'(k % 16), 8'd8, 1'b1));
    tick(153);
    bus_if.req = '0;
    tick(3);
    check("t3_timeouts", 32'(to_cnt - to_base), 32'd17);
    check("t3_ptr", 32'(dbg.ptr), 32'd1);

    // Grant on 9, then enable low with everyone requesting
    bus_if.req = 16'h0200;
    exp_q.push_back(mk(4'd9, 8'd3, 1'b0));
    tick(3);
    bus_if.enable = 1'b0;
    bus_if.req    = 16'hFFFF;
    tick(10);
    check("t4_no_grant", 32'(bus_if.grant_valid), 32'd0);
    check("t4_ptr", 32'(dbg.ptr), 32'd10);
    bus_if.req    = '0;
    bus_if.enable = 1'b1;
    tick(2);

    // req drop coincident with hold limit: ordinary release
    bus_if.req = 16'h0002;
    exp_q.push_back(mk(4'd1, 8'd8, 1'b0));
    tick(8);
    bus_if.req = '0;
    tick(3);
    check("t5_ptr", 32'(dbg.ptr), 32'd2);

    // enable drop coincident with hold limit: ordinary release
    bus_if.req = 16'h0004;
    exp_q.push_back(mk(4'd2, 8'd8, 1'b0));
    tick(8);
    bus_if.enable = 1'b0;
    tick(2);
    bus_if.req    = '0;
    tick(1);
    bus_if.enable = 1'b1;
    tick(2);
    check("t5b_ptr", 32'(dbg.ptr), 32'd3);

    // Asynchronous reset mid-grant on 12
    bus_if.req = 16'h1000;
    exp_q.push_back(mk(4'd12, 8'd0, 1'b0));
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("t6_grant",   32'(bus_if.grant), 32'd0);
    check("t6_id",      32'(bus_if.grant_id), 32'd0);
    check("t6_valid",   32'(bus_if.grant_valid), 32'd0);
    check("t6_timeout", 32'(bus_if.timeout), 32'd0);
    check("t6_state",   32'(dbg.state), 32'(IDLE));
    check("t6_ptr",     32'(dbg.ptr), 32'd0);
    bus_if.req = 16'h1001;
    tick(1);
    reset = 1'b0;
    exp_q.push_back(mk(4'd0, 8'd2, 1'b0));
    tick(2);
    bus_if.req = '0;
    tick(3);

    // Random single requesters with random tenure below the hold limit
    for (int i = 0; i < 6; i++) begin
      rid = $urandom_range(0, 15);
      rh  = $urandom_range(1, 7);
      bus_if.req = 16'h1 << rid;
      exp_q.push_back(mk(4'(rid), 8'(rh), 1'b0));
      tick(rh);
      bus_if.req = '0;
      tick(2);
      check("rand_ptr", 32'(dbg.ptr), 32'((rid + 1) % 16));
    end

    tick(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
